// File: rtl/timer_1ms_scheduler.sv
// Avalon-MM master that programs the interval timer, services its 1 ms interrupt,
// keeps a millisecond count and derives N_CH programmable-period tick channels.

module timer_ch_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        fire,
    input  logic        enable,
    input  logic [15:0] period,
    output logic        tick
);
    logic [15:0] cnt;

    // Tick is registered on the RUN->ACK edge so it lines up with the ACK write.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!enable || period == 16'd0) begin
                cnt <= '0;
            end else if (fire) begin
                // >= so a period shortened below the running count fires next ms
                if (cnt >= period - 16'd1) begin
                    tick <= 1'b1;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    end
endmodule

module timer_1ms_scheduler #(
    parameter int          N_CH         = 4,
    parameter logic [31:0] TIMER_PERIOD = 32'd49999
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [N_CH-1:0]       ch_enable,
    input  logic [N_CH-1:0][15:0] ch_period_ms,
    input  logic                  timer_irq,
    output logic [2:0]            avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic [15:0]           avm_writedata,
    output logic [N_CH-1:0]       ch_tick,
    output logic [31:0]           ms_count,
    output logic                  busy,
    output logic                  running
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WR_PL   = 4'd1;
    localparam logic [3:0] S_WR_PH   = 4'd2;
    localparam logic [3:0] S_WR_CTL  = 4'd3;
    localparam logic [3:0] S_WR_CLR  = 4'd4;
    localparam logic [3:0] S_RUN     = 4'd5;
    localparam logic [3:0] S_ACK     = 4'd6;
    localparam logic [3:0] S_SETTLE  = 4'd7;
    localparam logic [3:0] S_WR_STOP = 4'd8;

    logic [3:0] state;
    logic       stop_pend;
    logic       ch_clear;
    logic       ch_fire;

    assign ch_clear = (state == S_IDLE) && start;
    assign ch_fire  = (state == S_RUN) && timer_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
            ms_count  <= '0;
        end else begin
            if (state == S_IDLE)
                stop_pend <= 1'b0;
            else if (stop)
                stop_pend <= 1'b1;

            if (ch_clear)
                ms_count <= '0;
            else if (state == S_ACK)
                ms_count <= ms_count + 32'd1;

            case (state)
                S_IDLE:    if (start) state <= S_WR_PL;
                S_WR_PL:   state <= S_WR_PH;
                S_WR_PH:   state <= S_WR_CTL;
                S_WR_CTL:  state <= S_WR_CLR;
                S_WR_CLR:  state <= S_RUN;
                // A pending irq always wins over a pending stop
                S_RUN: begin
                    if (timer_irq)
                        state <= S_ACK;
                    else if (stop_pend)
                        state <= S_WR_STOP;
                end
                S_ACK:     state <= S_SETTLE;
                S_SETTLE:  state <= S_RUN;
                S_WR_STOP: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = 3'd0;
        avm_writedata  = 16'h0000;
        case (state)
            S_WR_PL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd2;
                avm_writedata  = TIMER_PERIOD[15:0];
            end
            S_WR_PH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd3;
                avm_writedata  = TIMER_PERIOD[31:16];
            end
            S_WR_CTL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd1;
                avm_writedata  = 16'h0001;
            end
            S_WR_CLR, S_ACK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
            end
            S_WR_STOP: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = 3'd1;
            end
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign running = (state == S_RUN) || (state == S_ACK) || (state == S_SETTLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            timer_ch_counter u_ch (
                .clk    (clk),
                .reset  (reset),
                .clear  (ch_clear),
                .fire   (ch_fire),
                .enable (ch_enable[gi]),
                .period (ch_period_ms[gi]),
                .tick   (ch_tick[gi])
            );
        end
    endgenerate
endmodule
